lifo_share_arb: RTL and testbench

- Shares one 1-bit, 8-deep LIFO stack between N_REQ requesters, arbitrated round-robin.
- Each requester issues a push or pop over a valid/ready request channel and receives a response over a valid/ready response channel.
- The block drives the stack's push, pop and data_in lines. It reads back data_out, full and empty.
- Sits between client logic and the stack instance. Both share clk and rst_n.

---
 rtl/lifo_share_arb.sv | 189 ++++++++++++++++++
 tb/tb_lifo_share_arb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_share_arb.sv
// Purpose : round-robin arbiter sharing one 1-bit x 8 LIFO between N_REQ requesters.
// Latency : request accept -> rsp_valid in 2 cycles (IDLE -> EXEC -> RESP); one op per 3 cycles peak.
// Backpres: response held in RESP until the owner's rsp_ready; no new grant is issued meanwhile.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_op/     per-requester request channel (op 1 = push, 0 = pop)
//   req_data
//   rsp_valid/rsp_ready             per-requester response channel; rsp_data/rsp_err shared
//   lifo_push/lifo_pop/lifo_data_in stack control, only active in EXEC
//   lifo_data_out/lifo_full/        stack status, sampled in EXEC
//   lifo_empty
//   occ/occ_hwm/err_cnt             shadow occupancy, its high-water mark and error count,
//                                   present only when LIFO_ARB_OCC_EN is defined
module lifo_share_arb #(
    parameter int N_REQ = 2,
    parameter int RID_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    input  logic [N_REQ-1:0] req_op,
    input  logic [N_REQ-1:0] req_data,
    output logic [N_REQ-1:0] rsp_valid,
    input  logic [N_REQ-1:0] rsp_ready,
    output logic             rsp_data,
    output logic             rsp_err,
    output logic             lifo_push,
    output logic             lifo_pop,
    output logic             lifo_data_in,
    input  logic             lifo_data_out,
    input  logic             lifo_full,
    input  logic             lifo_empty
`ifdef LIFO_ARB_OCC_EN
    ,
    output logic [3:0]       occ,
    output logic [3:0]       occ_hwm,
    output logic [7:0]       err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [RID_W-1:0] rr_ptr_q;
    logic [RID_W-1:0] owner_q;
    logic             op_q;
    logic             data_q;
    logic             rsp_data_q;
    logic             rsp_err_q;

    logic [RID_W-1:0] rr_ptr_d;
    logic [RID_W-1:0] hi_idx, lo_idx, win_idx;
    logic             hi_vld, lo_vld, win_vld;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] own_vec;
    logic             win_op, win_dat;
    logic             own_rdy;

    // Cyclic search from rr_ptr: the lowest valid index at or above the pointer
    // wins; if none exists, wrap to the lowest valid index overall. Scanning
    // downward lets the last hit be the lowest index.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                lo_vld = 1'b1;
                lo_idx = RID_W'(j);
                if (RID_W'(j) >= rr_ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = RID_W'(j);
                end
            end
        end
        win_vld = lo_vld;
        win_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_comb begin
        gnt     = '0;
        own_vec = '0;
        for (int j = 0; j < N_REQ; j++) begin
            gnt[j]     = win_vld && (win_idx == RID_W'(j));
            own_vec[j] = (owner_q == RID_W'(j));
        end
    end

    assign win_op  = |(gnt & req_op);
    assign win_dat = |(gnt & req_data);
    // rsp_ready on any index other than the owner has no effect.
    assign own_rdy = |(own_vec & rsp_ready);

    assign rr_ptr_d = (owner_q == RID_W'(N_REQ - 1)) ? '0 : owner_q + RID_W'(1);

    // req_ready is combinational from req_valid, so it is also masked by rst_n
    // to keep every output low while reset is asserted.
    assign req_ready    = (rst_n && state_q == IDLE) ? gnt : '0;
    assign rsp_valid    = (state_q == RESP) ? own_vec : '0;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    // Strobes are suppressed on full/empty so an erroring op leaves the stack untouched.
    assign lifo_push    = (state_q == EXEC) &&  op_q && !lifo_full;
    assign lifo_pop     = (state_q == EXEC) && !op_q && !lifo_empty;
    assign lifo_data_in = (state_q == EXEC) && data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            op_q       <= 1'b0;
            data_q     <= 1'b0;
            rsp_data_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        owner_q <= win_idx;
                        op_q    <= win_op;
                        data_q  <= win_dat;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_err_q  <= op_q ? lifo_full : lifo_empty;
                    // lifo_data_out is the top before this cycle's pop takes effect.
                    rsp_data_q <= (!op_q && !lifo_empty) ? lifo_data_out : 1'b0;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (own_rdy) begin
                        rr_ptr_q   <= rr_ptr_d;
                        rsp_data_q <= 1'b0;
                        rsp_err_q  <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LIFO_ARB_OCC_EN
    logic [3:0] occ_q, occ_d;
    logic [3:0] occ_hwm_q;
    logic [7:0] err_cnt_q;

    assign occ_d = occ_q + {3'b000, lifo_push} - {3'b000, lifo_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q     <= 4'd0;
            occ_hwm_q <= 4'd0;
            err_cnt_q <= 8'd0;
        end else begin
            occ_q <= occ_d;
            if (occ_d > occ_hwm_q) begin
                occ_hwm_q <= occ_d;
            end
            // Counted when the error response is actually delivered.
            if (state_q == RESP && own_rdy && rsp_err_q && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // Shadow count says the stack is full but the stack disagrees: the two have diverged.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(occ_q == 4'd8 && !lifo_full))
                else $error("lifo_share_arb: occ == 8 while lifo_full is low");
        end
    end

    assign occ     = occ_q;
    assign occ_hwm = occ_hwm_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_lifo_share_arb.sv
// Bench for lifo_share_arb with four requesters and an emulated 8-deep stack.
// Expected responses come from a queue-based model of the shared stack.
module tb_lifo_share_arb;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_valid, req_ready, req_op, req_data;
    logic [N-1:0] rsp_valid, rsp_ready;
    logic         rsp_data, rsp_err;
    logic         lifo_push, lifo_pop, lifo_data_in;
    logic         lifo_data_out, lifo_full, lifo_empty;

    int n_chk  = 0;
    int n_fail = 0;
    bit ref_stk[$];

    always #5 clk = ~clk;

    lifo_share_arb #(.N_REQ(N), .RID_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .lifo_push    (lifo_push),
        .lifo_pop     (lifo_pop),
        .lifo_data_in (lifo_data_in),
        .lifo_data_out(lifo_data_out),
        .lifo_full    (lifo_full),
        .lifo_empty   (lifo_empty)
    );

    // Emulated stack instance, reset by the same rst_n.
    logic [7:0] smem;
    logic [3:0] scnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= 4'd0;
            smem <= 8'd0;
        end else if (lifo_push && scnt < 4'd8) begin
            smem[scnt[2:0]] <= lifo_data_in;
            scnt            <= scnt + 4'd1;
        end else if (lifo_pop && scnt > 4'd0) begin
            scnt <= scnt - 4'd1;
        end
    end

    assign lifo_full     = (scnt == 4'd8);
    assign lifo_empty    = (scnt == 4'd0);
    assign lifo_data_out = (scnt != 4'd0) ? smem[scnt[2:0] - 3'd1] : 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    // One complete request from requester r, entered just after a negedge with
    // the DUT idle. stall = cycles the owner holds rsp_ready low.
    task automatic txn(input int r, input logic op, input logic d, input int stall);
        logic [N-1:0] one, oh;
        logic         e_err, e_dat, e_push, e_pop;
        one = 1;
        oh  = one << r;
        if (op) begin
            e_err  = (ref_stk.size() == 8);
            e_push = !e_err;
            e_pop  = 1'b0;
            e_dat  = 1'b0;
            if (!e_err) ref_stk.push_back(d);
        end else begin
            e_err  = (ref_stk.size() == 0);
            e_pop  = !e_err;
            e_push = 1'b0;
            e_dat  = e_err ? 1'b0 : ref_stk.pop_back();
        end
        req_valid = oh;
        req_op    = op ? oh : '0;
        req_data  = d ? oh : '0;
        rsp_ready = '0;
        #1;
        check("accept_ready", 32'(req_ready), 32'(oh));
        check("idle_strobes", {30'd0, lifo_push, lifo_pop}, 32'd0);
        @(negedge clk);
        // EXEC: request-side changes must have no effect from here on.
        req_valid = '1;
        req_op    = ~req_op;
        #1;
        check("exec_push", 32'(lifo_push), 32'(e_push));
        check("exec_pop", 32'(lifo_pop), 32'(e_pop));
        check("exec_ready", 32'(req_ready), 32'd0);
        if (e_push) check("exec_din", 32'(lifo_data_in), 32'(d));
        @(negedge clk);
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(oh));
        check("rsp_data", 32'(rsp_data), 32'(e_dat));
        check("rsp_err", 32'(rsp_err), 32'(e_err));
        check("resp_strobes", {30'd0, lifo_push, lifo_pop}, 32'd0);
        for (int s = 0; s < stall; s++) begin
            rsp_ready = ~oh;
            @(negedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid), 32'(oh));
            check("hold_data", {30'd0, rsp_data, rsp_err}, {30'd0, e_dat, e_err});
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_strobes", {30'd0, lifo_push, lifo_pop}, 32'd0);
        end
        rsp_ready = oh;
        req_valid = '0;
        @(negedge clk);
        rsp_ready = '0;
        #1;
        check("done_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [N-1:0] one;
        int           expg, g, nrsp;
        one       = 1;
        rst_n     = 1'b0;
        req_valid = '1;
        req_op    = '0;
        req_data  = '1;
        rsp_ready = '0;
        #1;
        check("reset_outputs",
              {22'd0, req_ready, rsp_valid, rsp_data, rsp_err, lifo_push, lifo_pop},
              32'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        #1;
        check("post_reset_idle", {26'd0, rsp_valid, rsp_data, rsp_err}, 32'd0);

        // First push, then drain, then 1,0,1 pushed and popped back in LIFO order,
        // then a pop on an empty stack.
        txn(0, 1'b1, 1'b1, 0);
        txn(1, 1'b0, 1'b0, 0);
        txn(0, 1'b1, 1'b1, 0);
        txn(0, 1'b1, 1'b0, 0);
        txn(0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 4; i++) txn(1, 1'b0, 1'b0, 0);

        // Fill to 8, then a 9th push to a full stack with a stalled response.
        for (int i = 0; i < 8; i++) txn(i % N, 1'b1, 1'(i % 3 == 0), 0);
        txn(0, 1'b1, 1'b1, 5);

        // Move the pointer to 2, then reset while requester 2 is in EXEC.
        txn(1, 1'b1, 1'b0, 0);
        req_valid = 4'b0100;
        req_op    = 4'b0000;
        req_data  = 4'b0100;
        @(negedge clk);
        #1;
        check("pre_reset_pop", 32'(lifo_pop), 32'd1);
        req_valid = 4'b1001;
        rst_n     = 1'b0;
        #1;
        check("mid_reset_outputs",
              {23'd0, req_ready, rsp_valid, rsp_data, lifo_push, lifo_pop, lifo_data_in} | {31'd0, rsp_err},
              32'd0);
        ref_stk.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_grant_after_reset", 32'(req_ready), 32'd1);
        req_valid = '0;

        // All four requesters continuously valid: grants must rotate.
        @(negedge clk);
        req_op    = '1;
        req_data  = 4'b0110;
        rsp_ready = '1;
        req_valid = '1;
        expg      = 0;
        g         = 0;
        nrsp      = 0;
        for (int c = 0; c < 40 && g < 6; c++) begin
            #1;
            if (req_ready != '0) begin
                check("rr_grant", 32'(req_ready), 32'(one << expg));
                ref_stk.push_back(req_data[expg]);
                expg = (expg + 1) % N;
                g++;
            end
            if (rsp_valid != '0) begin
                check("rr_rsp_err", 32'(rsp_err), 32'd0);
                nrsp++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (2) begin
            #1;
            if (rsp_valid != '0) nrsp++;
            @(negedge clk);
        end
        rsp_ready = '0;
        check("rr_grant_count", 32'(g), 32'd6);
        check("rr_rsp_count", 32'(nrsp), 32'd6);

        // Random traffic against the queue model.
        for (int i = 0; i < 80; i++) begin
            txn(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
